// File: rtl/mem_stage.sv
// MEM pipeline stage: holds the EX payload across an outstanding data-SRAM read and hands it to WB.
// Optional MEM_LD_EXT_EN: byte/halfword lane select and zero/sign extension of load data.
module mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ex_pc,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              ex_res_from_mem,
  input  logic              ex_gr_we,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic [2:0]        ex_ld_op,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] wb_pc,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_rdata,
  output logic              wb_res_from_mem,
  output logic              wb_gr_we,
  output logic [REG_AW-1:0] wb_dest,
  output logic              fwd_we,
  output logic [REG_AW-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_data,
  output logic              fwd_blocked
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state_r, state_next_s;
  logic [DATA_W-1:0]   pc_r, alu_result_r, rdata_r, rdata_cap_s;
  logic                res_from_mem_r, gr_we_r;
  logic [REG_AW-1:0]   dest_r;
  logic                valid_s, ready_go_s, accept_s, capture_s;

`ifdef MEM_LD_EXT_EN
  logic [2:0]          ld_op_r;

  // Lane-select and extend raw SRAM data; ld_op = {signed, size}, size 0=byte 1=half else word.
  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] data,
                                                 input logic [1:0] addr_lo,
                                                 input logic [2:0] ld_op);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    byte_v = data[{addr_lo, 3'b000} +: 8];
    half_v = data[{addr_lo[1], 4'b0000} +: 16];
    case (ld_op[1:0])
      2'd0:    load_ext = {{(DATA_W-8){ld_op[2] & byte_v[7]}}, byte_v};
      2'd1:    load_ext = {{(DATA_W-16){ld_op[2] & half_v[15]}}, half_v};
      default: load_ext = data;
    endcase
  endfunction

  assign rdata_cap_s = load_ext(data_sram_rdata, alu_result_r[1:0], ld_op_r);
`else
  logic unused_ld_op_s;
  assign unused_ld_op_s = ^ex_ld_op;
  assign rdata_cap_s    = data_sram_rdata;
`endif

  assign valid_s    = (state_r != EMPTY);
  assign ready_go_s = (state_r == HOLD);
  assign in_ready   = ~rst & ((state_r == EMPTY) | (ready_go_s & out_ready));
  assign accept_s   = in_valid & in_ready;
  // Responses only count while a load is outstanding; anything else is dropped.
  assign capture_s  = (state_r == WAIT) & data_sram_data_ok;

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      EMPTY: begin
        if (accept_s) state_next_s = ex_res_from_mem ? WAIT : HOLD;
        else          state_next_s = EMPTY;
      end
      WAIT: begin
        if (capture_s) state_next_s = HOLD;
        else           state_next_s = WAIT;
      end
      HOLD: begin
        if (accept_s)       state_next_s = ex_res_from_mem ? WAIT : HOLD;
        else if (out_ready) state_next_s = EMPTY;
        else                state_next_s = HOLD;
      end
      default: state_next_s = EMPTY;
    endcase
  end

  // State, payload and captured read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= EMPTY;
      pc_r           <= {DATA_W{1'b0}};
      alu_result_r   <= {DATA_W{1'b0}};
      res_from_mem_r <= 1'b0;
      gr_we_r        <= 1'b0;
      dest_r         <= {REG_AW{1'b0}};
      rdata_r        <= {DATA_W{1'b0}};
`ifdef MEM_LD_EXT_EN
      ld_op_r        <= 3'd0;
`endif
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        pc_r           <= ex_pc;
        alu_result_r   <= ex_alu_result;
        res_from_mem_r <= ex_res_from_mem;
        gr_we_r        <= ex_gr_we;
        dest_r         <= ex_dest;
`ifdef MEM_LD_EXT_EN
        ld_op_r        <= ex_ld_op;
`endif
      end
      if (capture_s) rdata_r <= rdata_cap_s;
    end
  end

  assign out_valid       = ready_go_s;
  assign wb_pc           = pc_r;
  assign wb_alu_result   = alu_result_r;
  assign wb_rdata        = rdata_r;
  assign wb_res_from_mem = res_from_mem_r;
  assign wb_gr_we        = gr_we_r;
  assign wb_dest         = dest_r;
  assign fwd_we          = valid_s & gr_we_r & (dest_r != {REG_AW{1'b0}});
  assign fwd_dest        = dest_r;
  assign fwd_data        = res_from_mem_r ? rdata_r : alu_result_r;
  // ID must stall when its source matches a load whose data has not arrived.
  assign fwd_blocked     = fwd_we & res_from_mem_r & (state_r == WAIT);

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; extension vectors depend on MEM_LD_EXT_EN.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] ex_pc, ex_alu_result;
  logic        ex_res_from_mem, ex_gr_we;
  logic [4:0]  ex_dest;
  logic [2:0]  ex_ld_op;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        out_valid, out_ready;
  logic [31:0] wb_pc, wb_alu_result, wb_rdata;
  logic        wb_res_from_mem, wb_gr_we;
  logic [4:0]  wb_dest;
  logic        fwd_we;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;
  logic        fwd_blocked;

  int tests = 0;
  int fails = 0;

  mem_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ex_pc(ex_pc), .ex_alu_result(ex_alu_result), .ex_res_from_mem(ex_res_from_mem),
    .ex_gr_we(ex_gr_we), .ex_dest(ex_dest), .ex_ld_op(ex_ld_op),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_pc(wb_pc), .wb_alu_result(wb_alu_result), .wb_rdata(wb_rdata),
    .wb_res_from_mem(wb_res_from_mem), .wb_gr_we(wb_gr_we), .wb_dest(wb_dest),
    .fwd_we(fwd_we), .fwd_dest(fwd_dest), .fwd_data(fwd_data), .fwd_blocked(fwd_blocked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] pc, input logic [31:0] addr, input logic ld,
                         input logic [4:0] dest, input logic [2:0] op);
    in_valid        = 1'b1;
    ex_pc           = pc;
    ex_alu_result   = addr;
    ex_res_from_mem = ld;
    ex_gr_we        = 1'b1;
    ex_dest         = dest;
    ex_ld_op        = op;
  endtask

  // Load accepted, one idle WAIT cycle, then the response; leaves the stage in HOLD.
  task automatic do_load(input logic [31:0] addr, input logic [2:0] op, input logic [31:0] data);
    present(32'h1c000100, addr, 1'b1, 5'd9, op);
    tick();
    in_valid = 1'b0;
    tick();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = data;
    tick();
    data_sram_data_ok = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; ex_pc = 32'h0; ex_alu_result = 32'h0; ex_res_from_mem = 1'b0;
    ex_gr_we = 1'b0; ex_dest = 5'd0; ex_ld_op = 3'd0;
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0; out_ready = 1'b1;
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_wb_pc", wb_pc, 32'h0);
    chk("rst_fwd_we", {31'd0, fwd_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Non-load
    present(32'h1c000000, 32'h5, 1'b0, 5'd3, 3'd2);
    tick();
    in_valid = 1'b0;
    chk("alu_out_valid", {31'd0, out_valid}, 32'd1);
    chk("alu_wb_pc", wb_pc, 32'h1c000000);
    chk("alu_wb_result", wb_alu_result, 32'h5);
    chk("alu_fwd_we", {31'd0, fwd_we}, 32'd1);
    chk("alu_fwd_dest", {27'd0, fwd_dest}, 32'd3);
    chk("alu_fwd_data", fwd_data, 32'h5);
    chk("alu_fwd_blocked", {31'd0, fwd_blocked}, 32'd0);
    tick();
    chk("alu_drained", {31'd0, out_valid}, 32'd0);

    // Load, 3-cycle response; data_ok in the accept cycle must be ignored
    present(32'h1c000004, 32'h100, 1'b1, 5'd4, 3'd2);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h11111111;
    tick();
    in_valid = 1'b0;
    data_sram_data_ok = 1'b0;
    chk("ld_wait_blocked", {31'd0, fwd_blocked}, 32'd1);
    chk("ld_wait_in_ready", {31'd0, in_ready}, 32'd0);
    chk("ld_wait_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("ld_wait2_blocked", {31'd0, fwd_blocked}, 32'd1);
    chk("ld_wait2_out_valid", {31'd0, out_valid}, 32'd0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hdeadbeef;
    tick();
    data_sram_data_ok = 1'b0;
    chk("ld_out_valid", {31'd0, out_valid}, 32'd1);
    chk("ld_wb_rdata", wb_rdata, 32'hdeadbeef);
    chk("ld_fwd_data", fwd_data, 32'hdeadbeef);
    chk("ld_fwd_blocked", {31'd0, fwd_blocked}, 32'd0);
    chk("ld_wb_res_from_mem", {31'd0, wb_res_from_mem}, 32'd1);

    // Spurious data_ok in HOLD under backpressure
    out_ready = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h12345678;
    tick();
    data_sram_data_ok = 1'b0;
    chk("spur_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("spur_hold_rdata", wb_rdata, 32'hdeadbeef);

    // WB backpressure with next instruction waiting in EX
    present(32'h1c000008, 32'h77, 1'b0, 5'd5, 3'd2);
    for (int i = 0; i < 4; i++) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_wb_pc", wb_pc, 32'h1c000004);
      chk("bp_wb_dest", {27'd0, wb_dest}, 32'd4);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("b2b_out_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_wb_pc", wb_pc, 32'h1c000008);
    chk("b2b_wb_result", wb_alu_result, 32'h77);
    chk("b2b_wb_dest", {27'd0, wb_dest}, 32'd5);
    chk("b2b_res_from_mem", {31'd0, wb_res_from_mem}, 32'd0);
    chk("b2b_rdata_kept", wb_rdata, 32'hdeadbeef);
    tick();
    chk("b2b_drained", {31'd0, out_valid}, 32'd0);

    // Spurious data_ok in EMPTY
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h12345678;
    tick();
    data_sram_data_ok = 1'b0;
    chk("spur_empty_valid", {31'd0, out_valid}, 32'd0);
    chk("spur_empty_rdata", wb_rdata, 32'hdeadbeef);
    chk("spur_empty_in_ready", {31'd0, in_ready}, 32'd1);

    // dest 0 never forwards
    present(32'h1c000010, 32'h42, 1'b0, 5'd0, 3'd2);
    tick();
    in_valid = 1'b0;
    chk("r0_out_valid", {31'd0, out_valid}, 32'd1);
    chk("r0_fwd_we", {31'd0, fwd_we}, 32'd0);
    tick();

    // Async reset mid-WAIT
    present(32'h1c000020, 32'h200, 1'b1, 5'd6, 3'd2);
    tick();
    in_valid = 1'b0;
    chk("rw_blocked", {31'd0, fwd_blocked}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rw_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rw_fwd_we", {31'd0, fwd_we}, 32'd0);
    chk("rw_fwd_blocked", {31'd0, fwd_blocked}, 32'd0);
    chk("rw_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rw_wb_pc", wb_pc, 32'h0);
    chk("rw_wb_alu", wb_alu_result, 32'h0);
    chk("rw_wb_rdata", wb_rdata, 32'h0);
    chk("rw_wb_dest", {27'd0, wb_dest}, 32'd0);
    chk("rw_wb_flags", {30'd0, wb_gr_we, wb_res_from_mem}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rw_rel_in_ready", {31'd0, in_ready}, 32'd1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hcafef00d;
    tick();
    data_sram_data_ok = 1'b0;
    chk("rw_stale_ignored", {31'd0, out_valid}, 32'd0);
    present(32'h1c00000c, 32'h9, 1'b0, 5'd7, 3'd2);
    tick();
    in_valid = 1'b0;
    chk("rw_new_valid", {31'd0, out_valid}, 32'd1);
    chk("rw_new_fwd_data", fwd_data, 32'h9);
    chk("rw_new_rdata", wb_rdata, 32'h0);
    tick();

    // Sub-word loads
    do_load(32'h1c000102, 3'b100, 32'h00800000);
`ifdef MEM_LD_EXT_EN
    chk("ext_lb", wb_rdata, 32'hffffff80);
`else
    chk("raw_lb", wb_rdata, 32'h00800000);
`endif
    tick();
    do_load(32'h1c000102, 3'b001, 32'h80000000);
`ifdef MEM_LD_EXT_EN
    chk("ext_lhu", wb_rdata, 32'h00008000);
`else
    chk("raw_lhu", wb_rdata, 32'h80000000);
`endif
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
